multdiv_seq: RTL and testbench

- Multi-cycle signed 32-bit multiply/divide unit for the CP processor datapath.
- Sits beside the combinational ALU on the operand buses.
- Where the ALU answers in the same cycle, this block accepts a one-cycle start pulse, iterates, and returns a result with a one-cycle ready strobe.
- The pipeline stalls on it between start and ready.

---
 rtl/multdiv_seq.sv | 193 +++++++++++++++++++
 tb/tb_multdiv_seq.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/multdiv_seq.sv
// Multi-cycle signed multiply (radix-4 Booth) / divide (non-restoring) unit.
// Optional MULTDIV_EARLY_ZERO_EN: zero-operand starts complete in one cycle.
module multdiv_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] MUL_STEPS = CW'(WIDTH / 2);
  localparam logic [CW-1:0] DIV_STEPS = CW'(WIDTH);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t state, state_next;

  // hi/lo double as Booth product register and divider remainder/quotient
  logic [WIDTH+1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] mcand;
  logic             bprev;
  logic [CW-1:0]    cnt;
  logic             neg_q;
  logic             div_zero;
  logic             div_ovf;

  logic             start;
  logic             early_zero;
  logic             early_exc;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;

  assign start = ctrl_MULT | ctrl_DIV;
  assign abs_a = data_operandA[WIDTH-1] ? (~data_operandA + 1'b1) : data_operandA;
  assign abs_b = data_operandB[WIDTH-1] ? (~data_operandB + 1'b1) : data_operandB;

`ifdef MULTDIV_EARLY_ZERO_EN
  assign early_zero = (data_operandA == '0) | (data_operandB == '0);
  assign early_exc  = ~ctrl_MULT & (data_operandB == '0);
`else
  assign early_zero = 1'b0;
  assign early_exc  = 1'b0;
`endif

  // Booth step
  logic [2:0]         win;
  logic [WIDTH+1:0]   mc_ext;
  logic [WIDTH+1:0]   pp;
  logic [WIDTH+1:0]   acc_sum;
  logic [2*WIDTH+1:0] cat;
  logic [2*WIDTH+1:0] mul_shift;
  logic               mul_exc;

  always_comb begin
    win    = {lo[1:0], bprev};
    mc_ext = {{2{mcand[WIDTH-1]}}, mcand};
    pp     = '0;
    case (win)
      3'b001, 3'b010: pp = mc_ext;
      3'b011:         pp = mc_ext << 1;
      3'b100:         pp = ~(mc_ext << 1) + 1'b1;
      3'b101, 3'b110: pp = ~mc_ext + 1'b1;
      default:        pp = '0;
    endcase
    acc_sum   = hi + pp;
    cat       = {acc_sum, lo};
    mul_shift = {{2{cat[2*WIDTH+1]}}, cat[2*WIDTH+1:2]};
    mul_exc   = (hi[WIDTH-1:0] != {WIDTH{lo[WIDTH-1]}});
  end

  // Non-restoring step: quotient bits come out directly; remainder is unused
  logic [WIDTH+1:0] rem_sh;
  logic [WIDTH+1:0] dvs_ext;
  logic [WIDTH+1:0] rem_new;
  logic [WIDTH-1:0] lo_div;
  logic [WIDTH-1:0] div_res;
  logic             div_exc;

  always_comb begin
    rem_sh  = {hi[WIDTH:0], lo[WIDTH-1]};
    dvs_ext = {2'b00, mcand};
    rem_new = hi[WIDTH+1] ? (rem_sh + dvs_ext) : (rem_sh - dvs_ext);
    lo_div  = {lo[WIDTH-2:0], ~rem_new[WIDTH+1]};
    div_exc = div_zero | div_ovf;
    if (div_zero)
      div_res = '0;
    else if (neg_q)
      div_res = ~lo + 1'b1;
    else
      div_res = lo;
  end

  always_comb begin
    state_next = state;
    if (start) begin
      if (early_zero)
        state_next = DONE;
      else if (ctrl_MULT)
        state_next = MUL;
      else
        state_next = DIV;
    end else begin
      case (state)
        MUL:     if (cnt == MUL_STEPS) state_next = DONE;
        DIV:     if (cnt == DIV_STEPS) state_next = DONE;
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      state <= IDLE;
    else
      state <= state_next;
  end

  assign data_resultRDY = (state == DONE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hi             <= '0;
      lo             <= '0;
      mcand          <= '0;
      bprev          <= 1'b0;
      cnt            <= '0;
      neg_q          <= 1'b0;
      div_zero       <= 1'b0;
      div_ovf        <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
      busy           <= 1'b0;
    end else if (start) begin
      hi       <= '0;
      bprev    <= 1'b0;
      cnt      <= '0;
      neg_q    <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      div_zero <= (data_operandB == '0);
      div_ovf  <= (data_operandA == MIN_NEG) && (data_operandB == '1);
      busy     <= ~early_zero;
      if (ctrl_MULT) begin
        mcand <= data_operandA;
        lo    <= data_operandB;
      end else begin
        mcand <= abs_b;
        lo    <= abs_a;
      end
      if (early_zero) begin
        data_result    <= '0;
        data_exception <= early_exc;
      end
    end else begin
      case (state)
        MUL: begin
          if (cnt == MUL_STEPS) begin
            data_result    <= lo;
            data_exception <= mul_exc;
            busy           <= 1'b0;
          end else begin
            hi    <= mul_shift[2*WIDTH+1:WIDTH];
            lo    <= mul_shift[WIDTH-1:0];
            bprev <= lo[1];
            cnt   <= cnt + 1'b1;
          end
        end
        DIV: begin
          if (cnt == DIV_STEPS) begin
            data_result    <= div_res;
            data_exception <= div_exc;
            busy           <= 1'b0;
          end else begin
            hi  <= rem_new;
            lo  <= lo_div;
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multdiv_seq.sv
// Randomized self-checking bench for multdiv_seq against a behavioural * and / model.
module tb_multdiv_seq;

  logic        clock;
  logic        reset_n;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  int unsigned n_tests;
  int unsigned n_fail;

  multdiv_seq #(.WIDTH(32)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: full-precision signed arithmetic
  task automatic model(input bit is_mul, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output logic exc, output int lat);
    longint prod;
    int     q;
    if (is_mul) begin
      prod = longint'($signed(a)) * longint'($signed(b));
      res  = prod[31:0];
      exc  = (prod != longint'($signed(prod[31:0])));
      lat  = 17;
    end else begin
      lat = 33;
      if (b == 32'd0) begin
        res = 32'd0;
        exc = 1'b1;
      end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        res = 32'h8000_0000;
        exc = 1'b1;
      end else begin
        q   = $signed(a) / $signed(b);
        res = q;
        exc = 1'b0;
      end
    end
`ifdef MULTDIV_EARLY_ZERO_EN
    if (a == 32'd0 || b == 32'd0) lat = 0;
`endif
  endtask

  // Latency counted in rising edges after the start edge
  task automatic run_op(input bit is_mul, input logic [31:0] a, input logic [31:0] b,
                        input string tag, input bit chk_busy);
    logic [31:0] exp_res;
    logic        exp_exc;
    int          exp_lat;
    int          lat;
    int          busy_cnt;
    model(is_mul, a, b, exp_res, exp_exc, exp_lat);
    @(negedge clock);
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT     = is_mul;
    ctrl_DIV      = ~is_mul;
    @(negedge clock);
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
    lat      = 0;
    busy_cnt = busy ? 1 : 0;
    while (!data_resultRDY && lat < 100) begin
      @(negedge clock);
      lat++;
      if (busy) busy_cnt++;
    end
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check({tag, "_res"}, 64'(data_result), 64'(exp_res));
    check({tag, "_exc"}, 64'(data_exception), 64'(exp_exc));
    if (chk_busy) check({tag, "_busy"}, 64'(busy_cnt), 64'(exp_lat));
    @(negedge clock);
    check({tag, "_rdy_width"}, 64'(data_resultRDY), 64'd0);
  endtask

  function automatic logic [31:0] rnd_operand();
    logic [31:0] v;
    case ($urandom_range(0, 9))
      0: v = 32'h8000_0000;
      1: v = 32'hFFFF_FFFF;
      2: v = 32'(signed'($urandom_range(0, 20)) - 10);
      3: v = $urandom_range(0, 65535);
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    int rdy_cnt;
    int lat;
    int first_lat;
    logic [31:0] res_at_rdy;
    n_tests = 0;
    n_fail  = 0;
    reset_n = 1'b0;
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    repeat (3) @(negedge clock);
    check("reset_out", {data_result, data_exception, data_resultRDY, busy}, 64'd0);
    reset_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      check("idle_out", {data_result, data_exception, data_resultRDY, busy}, 64'd0);
    end

    run_op(1'b1, 32'h0000_0007, 32'hFFFF_FFFD, "mul_7xm3", 1'b1);
    run_op(1'b1, 32'h0001_0000, 32'h0001_0000, "mul_ovf16", 1'b0);
    run_op(1'b1, 32'h7FFF_FFFF, 32'h0000_0002, "mul_ovfmax", 1'b0);
    run_op(1'b0, 32'hFFFF_FFF9, 32'h0000_0002, "div_m7d2", 1'b1);
    run_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf", 1'b0);
    run_op(1'b0, 32'h0000_0005, 32'h0000_0000, "div_zero", 1'b0);
    run_op(1'b1, 32'h8000_0000, 32'h8000_0000, "mul_minmin", 1'b0);

    // Abort: DIV 100/7, MULT 6*7 pulsed ten cycles later
    @(negedge clock);
    data_operandA = 32'd100;
    data_operandB = 32'd7;
    ctrl_DIV = 1'b1;
    @(negedge clock);
    ctrl_DIV = 1'b0;
    rdy_cnt = 0;
    repeat (8) begin
      @(negedge clock);
      if (data_resultRDY) rdy_cnt++;
    end
    @(negedge clock);
    data_operandA = 32'd6;
    data_operandB = 32'd7;
    ctrl_MULT = 1'b1;
    @(negedge clock);
    ctrl_MULT = 1'b0;
    first_lat  = -1;
    res_at_rdy = '0;
    for (lat = 1; lat <= 60; lat++) begin
      @(negedge clock);
      if (data_resultRDY) begin
        rdy_cnt++;
        if (first_lat < 0) begin
          first_lat  = lat;
          res_at_rdy = data_result;
        end
      end
    end
    check("abort_rdy_count", 64'(rdy_cnt), 64'd1);
    check("abort_lat", 64'(first_lat), 64'd17);
    check("abort_res", 64'(res_at_rdy), 64'd42);

    // Reset mid-operation
    @(negedge clock);
    data_operandA = 32'd100;
    data_operandB = 32'd7;
    ctrl_DIV = 1'b1;
    @(negedge clock);
    ctrl_DIV = 1'b0;
    repeat (8) @(negedge clock);
    #2 reset_n = 1'b0;
    #1 check("async_reset_out", {data_result, data_exception, data_resultRDY, busy}, 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    rdy_cnt = 0;
    repeat (50) begin
      @(negedge clock);
      if (data_resultRDY) rdy_cnt++;
    end
    check("reset_abort_rdy", 64'(rdy_cnt), 64'd0);

    for (int i = 0; i < 1000; i++) begin
      run_op(1'b1, rnd_operand(), rnd_operand(), "rnd_mul", 1'b0);
      run_op(1'b0, rnd_operand(), rnd_operand(), "rnd_div", 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
